// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    localparam int SERIAL_ADDER_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Full-adder cell built from two half-adders; the carries of the two
// stages can never both be set, so OR-ing them gives the carry out.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s1;
    logic c1;
    logic c2;

    ha u_ha0 (
        .a (a),
        .b (b),
        .s (s1),
        .c (c1)
    );

    ha u_ha1 (
        .a (s1),
        .b (cin),
        .s (s),
        .c (c2)
    );

    assign cout = c1 | c2;

endmodule

// File: rtl/ha.sv
// Half-adder cell: sum and carry of two single bits.
module ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are loaded on start, summed LSB-first
// through one full-adder cell with a registered carry, and the result is
// presented with a one-cycle done pulse.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow
// output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADDER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] rs_q, rs_d;
    logic             cy_q, cy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             fa_s;
    logic             fa_co;

    full_adder u_fa (
        .a    (ra_q[0]),
        .b    (rb_q[0]),
        .cin  (cy_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    // Next-state and datapath: load in IDLE, shift one bit per cycle in RUN,
    // capture the result on the last RUN cycle, pulse done in DONE.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rs_d    = rs_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    rs_d    = '0;
                    cy_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                rs_d  = {fa_s, rs_q[WIDTH-1:1]};
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                cy_d  = fa_co;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // The MSB is processed this cycle, so the result is taken
                    // from the shift-register input rather than its output.
                    state_d = DONE;
                    cnt_d   = '0;
                    sum_d   = {fa_s, rs_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    done_d  = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = fa_co ^ cy_q;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rs_q    <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rs_q    <= rs_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): directed operations push the
// expected {sum, cout, ovf} into a queue; a negedge monitor pops and compares
// whenever done is seen. Build with SERIAL_ADDER_OVF_EN to also check ovf.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int failures = 0;

    logic [W+1:0] sb_q[$];

    int  cyc = 0;
    bit  b2b = 1'b0;
    int  last_done_cyc = -1;
    logic [W-1:0] prev_sum = '0;
    logic prev_rst_n = 1'b0;
    logic prev_done = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every done, checks done is a single
    // pulse, sum holds between completions, and done spacing when streaming.
    always @(negedge clk) begin
        logic [W+1:0] e;
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sum", 32'(sum), 32'(e[W+1:2]));
                chk("cout", 32'(cout), 32'(e[1]));
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf", 32'(ovf), 32'(e[0]));
`endif
            end
            if (prev_done) chk("done_pulse_width", 32'd2, 32'd1);
            if (b2b && last_done_cyc >= 0) chk("done_spacing", 32'(cyc - last_done_cyc), 32'd10);
            last_done_cyc = cyc;
        end
        if (rst_n && prev_rst_n && !done && sum !== prev_sum)
            chk("sum_hold", 32'(sum), 32'(prev_sum));
        prev_sum   = sum;
        prev_rst_n = rst_n;
        prev_done  = rst_n && done;
    end

    // One add: start for one cycle, measure start-to-done latency and busy
    // length; optionally fire an extra start inj cycles into the run.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input int inj);
        int  lat;
        int  busy_cnt;
        bit  seen;
        @(negedge clk);
        start = 1'b1; a = ia; b = ib;
        sb_q.push_back({es, ec, eo});
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0; busy_cnt = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
            else lat++;
            if (inj != 0 && lat == inj && !seen) begin
                start = 1'b1; a = 8'hAA; b = 8'h55;
            end else begin
                start = 1'b0;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(lat), 32'(W));
        chk("busy_cycles", 32'(busy_cnt), 32'(W + 1));
        @(negedge clk);
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_after", 32'(done), 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op(8'h03, 8'h05, 8'h08, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0);
        run_op(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 0);
        run_op(8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0, 0);
        run_op(8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 0);
        run_op(8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0, 0);
        // Start while busy: the AA+55 request must be ignored.
        run_op(8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 3);
        repeat (12) @(negedge clk);

        // Reset during RUN cycle 4: operation discarded, no done.
        @(negedge clk);
        start = 1'b1; a = 8'h11; b = 8'h22;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("midrst_ovf", 32'(ovf), 32'd0);
`endif
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (14) @(negedge clk);
        chk("midrst_idle_busy", 32'(busy), 32'd0);
        run_op(8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 0);

        // Start held high: accepted at offsets 0, 10, 20 with a = offset.
        sb_q.push_back({8'h40, 1'b0, 1'b0});
        sb_q.push_back({8'h4A, 1'b0, 1'b0});
        sb_q.push_back({8'h54, 1'b0, 1'b0});
        b2b = 1'b1;
        last_done_cyc = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            start = 1'b1; a = 8'(i); b = 8'h40;
        end
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        b2b = 1'b0;

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
